// File: rtl/decode_issue_unit_pkg.sv
// Shared opcode constants, decoded-instruction record and helpers for the
// decode/issue stage.
package decode_issue_unit_pkg;

  localparam logic [5:0] OP_LINK_A  = 6'd37;
  localparam logic [5:0] OP_LINK_B  = 6'd38;
  localparam logic [5:0] OP_LINK_C  = 6'd40;
  localparam logic [5:0] OP_GEN_LO  = 6'd8;
  localparam logic [5:0] OP_GEN_HI  = 6'd29;
  localparam logic [5:0] OP_FLT_LO  = 6'd54;
  localparam logic [5:0] OP_FLT_HI  = 6'd63;
  localparam logic [5:0] OP_RT_TOP  = 6'd60;
  localparam logic [4:0] LINK_REG   = 5'd31;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shift5;
    logic [15:0] const16;
    logic [25:0] addr26;
    logic [4:0]  dest;
    logic        is_general;
    logic        is_float;
  } decoded_inst_t;

  function automatic logic is_link(input logic [5:0] op);
    return (op == OP_LINK_A) || (op == OP_LINK_B) || (op == OP_LINK_C);
  endfunction

endpackage

// File: rtl/decode_issue_unit_field_decode.sv
// Pure combinational field extraction and destination/register-file
// classification of one 32-bit instruction word.
module inst_field_decode
  import decode_issue_unit_pkg::*;
(
  input  logic [31:0]   inst,
  output decoded_inst_t dec
);

  logic [5:0] op;
  logic       rt_dest;

  assign op = inst[31:26];

  always_comb begin
    dec            = '0;
    dec.opcode     = op;
    dec.rs         = inst[25:21];
    dec.rt         = inst[20:16];
    dec.rd         = inst[15:11];
    dec.shift5     = inst[10:6];
    dec.const16    = inst[15:0];
    dec.addr26     = inst[25:0];

    rt_dest = (op inside {6'd9, 6'd11, 6'd14, 6'd15, 6'd21, 6'd23, 6'd25,
                          6'd28, 6'd42, 6'd48, 6'd52, 6'd53, 6'd54, 6'd55})
              || (op >= OP_RT_TOP);

    // Link ops always write the link register regardless of encoded fields.
    if (is_link(op))
      dec.dest = LINK_REG;
    else if (rt_dest)
      dec.dest = dec.rt;
    else
      dec.dest = dec.rd;

    dec.is_general = (op == 6'd6) || (op >= OP_GEN_LO && op <= OP_GEN_HI)
                     || is_link(op) || (op == 6'd42) || (op == 6'd53);
    dec.is_float   = (op == 6'd48) || (op == 6'd49) || (op == 6'd52)
                     || (op >= OP_FLT_LO && op <= OP_FLT_HI);
  end

endmodule

// File: rtl/decode_issue_unit.sv
// Instruction queue feeding a combinational decoder, with general/float
// pending-write scoreboards gating issue.
module decode_issue_unit
  import decode_issue_unit_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_WB      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_inst_num,
  output logic [15:0]            out_const16,
  output logic [4:0]             out_shift5,
  output logic [25:0]            out_addr26,
  output logic [2:0][4:0]        out_in_reg_num,
  output logic [4:0]             out_reg_num,
  output logic                   out_general_reg,
  output logic                   out_float_reg,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB-1:0]      wb_float,
  input  logic [NUM_WB-1:0][4:0] wb_reg,
  input  logic                   flush
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [31:0]    queue [QUEUE_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [31:0]    gen_sb, flt_sb, gen_sb_next, flt_sb_next;
  decoded_inst_t  head;
  logic           full, empty, hazard, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_ready  = !full;
  assign push      = in_valid && in_ready && !flush;
  assign out_valid = !empty && !hazard && !flush;
  assign pop       = out_valid && out_ready;

  inst_field_decode u_decode (
    .inst (queue[rd_ptr[PTR_W-1:0]]),
    .dec  (head)
  );

  assign hazard = gen_sb[head.rs] || flt_sb[head.rs] ||
                  gen_sb[head.rt] || flt_sb[head.rt] ||
                  (head.is_general && gen_sb[head.dest]) ||
                  (head.is_float && flt_sb[head.dest]);

  // Flush drops everything queued by catching the read pointer up to the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        queue[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        queue[wr_ptr[PTR_W-1:0]] <= in_inst;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Clears are applied first so an issue to the same register overrides them.
  always_comb begin
    gen_sb_next = gen_sb;
    flt_sb_next = flt_sb;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i]) begin
        if (wb_float[i])
          flt_sb_next[wb_reg[i]] = 1'b0;
        else
          gen_sb_next[wb_reg[i]] = 1'b0;
      end
    end
    if (pop) begin
      if (head.is_general && head.dest != 5'd0)
        gen_sb_next[head.dest] = 1'b1;
      if (head.is_float)
        flt_sb_next[head.dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_sb <= '0;
      flt_sb <= '0;
    end else begin
      gen_sb <= gen_sb_next;
      flt_sb <= flt_sb_next;
    end
  end

  assign out_inst_num      = head.opcode;
  assign out_const16       = head.const16;
  assign out_shift5        = head.shift5;
  assign out_addr26        = head.addr26;
  assign out_in_reg_num[0] = head.rs;
  assign out_in_reg_num[1] = head.rt;
  assign out_in_reg_num[2] = head.rd;
  assign out_reg_num       = head.dest;
  assign out_general_reg   = head.is_general;
  assign out_float_reg     = head.is_float;

endmodule
